// File: rtl/stim_pkg.sv
// Shared state encoding and table-entry layout for board_stim_seq.
// Entry, LSB first: gpio, key, sw, hold, then exp when STIM_CHECK_EN.
package stim_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RSTP = 2'd1,
        S_PLAY = 2'd2,
        S_DONE = 2'd3
    } state_t;

`ifdef STIM_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    function automatic int off_key(
        input int gpio_w
    );
        return gpio_w;
    endfunction

    function automatic int off_sw(
        input int gpio_w,
        input int key_w
    );
        return gpio_w + key_w;
    endfunction

    function automatic int off_hold(
        input int gpio_w,
        input int key_w,
        input int sw_w
    );
        return gpio_w + key_w + sw_w;
    endfunction

    function automatic int off_exp(
        input int gpio_w,
        input int key_w,
        input int sw_w,
        input int hold_w
    );
        return gpio_w + key_w + sw_w + hold_w;
    endfunction

    function automatic int entry_w(
        input int gpio_w,
        input int key_w,
        input int sw_w,
        input int hold_w,
        input int obs_w
    );
        return off_exp(gpio_w, key_w, sw_w, hold_w)
             + (CHECK_EN ? obs_w : 0);
    endfunction

endpackage

// File: rtl/stim_table.sv
// Stimulus table: synchronous write, asynchronous read.
// Contents are deliberately left unreset.
module stim_table #(
    parameter int DEPTH = 16,
    parameter int EW    = 60
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [EW-1:0]            wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [EW-1:0]            rdata_o
);

    logic [EW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/board_stim_seq.sv
// Board stimulus sequencer: DUT reset pulse, then table playback.
// Define STIM_CHECK_EN to add OBS checking with MISCNT/MISIDX outputs.
module board_stim_seq
    import stim_pkg::*;
#(
    parameter int SW_W    = 10,
    parameter int KEY_W   = 2,
    parameter int GPIO_W  = 32,
    parameter int DEPTH   = 16,
    parameter int HOLD_W  = 16,
    parameter int RST_CYC = 2,
    parameter int OBS_W   = 5
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       WE,
    input  logic [$clog2(DEPTH)-1:0]   WADDR,
    input  logic [entry_w(GPIO_W, KEY_W, SW_W,
                          HOLD_W, OBS_W)-1:0] WDATA,
    input  logic [$clog2(DEPTH):0]     LEN,
    input  logic                       LOOP,
    input  logic                       START,
    input  logic                       ABORT,
    input  logic [OBS_W-1:0]           OBS,
    output logic                       DUT_RST,
    output logic [SW_W-1:0]            SW,
    output logic [KEY_W-1:0]           KEY,
    output logic [GPIO_W-1:0]          GPIO,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [$clog2(DEPTH)-1:0]   IDX
`ifdef STIM_CHECK_EN
    ,
    output logic [15:0]                MISCNT,
    output logic [$clog2(DEPTH)-1:0]   MISIDX
`endif
);

    localparam int IW    = $clog2(DEPTH);
    localparam int LW    = IW + 1;
    localparam int EW    = entry_w(GPIO_W, KEY_W, SW_W, HOLD_W, OBS_W);
    localparam int O_KEY = off_key(GPIO_W);
    localparam int O_SW  = off_sw(GPIO_W, KEY_W);
    localparam int O_HLD = off_hold(GPIO_W, KEY_W, SW_W);
    localparam int RCW   = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    state_t            state_q;
    logic              dut_rst_q;
    logic              busy_q;
    logic              done_q;
    logic              loop_q;
    logic [SW_W-1:0]   sw_q;
    logic [KEY_W-1:0]  key_q;
    logic [GPIO_W-1:0] gpio_q;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     idx_d;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     len_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic [RCW-1:0]    rcnt_q;
    logic [EW-1:0]     ent;
    logic [HOLD_W-1:0] ent_hold;
    logic              last;
    logic              we_ok;
    logic              start_ok;

`ifdef STIM_CHECK_EN
    localparam int O_EXP = off_exp(GPIO_W, KEY_W, SW_W, HOLD_W);
    logic [OBS_W-1:0] exp_q;
    logic [15:0]      miscnt_q;
    logic [IW-1:0]    misidx_q;
`else
    logic unused_obs;
    assign unused_obs = ^OBS;
`endif

    assign we_ok    = WE && (state_q == S_IDLE || state_q == S_DONE);
    assign start_ok = START && (LEN != '0);
    assign len_d    = (LEN > LW'(DEPTH)) ? LW'(DEPTH) : LEN;
    assign last     = ({1'b0, idx_q} == len_q - LW'(1));
    // The single read port always points at the entry to load next.
    assign idx_d    = (state_q == S_PLAY && !last) ? idx_q + IW'(1) : '0;
    assign ent_hold = ent[O_HLD +: HOLD_W];
    assign hold_d   = (ent_hold == '0) ? '0 : ent_hold - HOLD_W'(1);

    stim_table #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_table (
        .clk_i   (CLK),
        .we_i    (we_ok),
        .waddr_i (WADDR),
        .wdata_i (WDATA),
        .raddr_i (idx_d),
        .rdata_o (ent)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            dut_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            loop_q    <= 1'b0;
            len_q     <= '0;
            sw_q      <= '0;
            key_q     <= '0;
            gpio_q    <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            rcnt_q    <= '0;
`ifdef STIM_CHECK_EN
            exp_q     <= '0;
            miscnt_q  <= '0;
            misidx_q  <= '0;
`endif
        end else if (ABORT) begin
            state_q   <= S_IDLE;
            dut_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sw_q      <= '0;
            key_q     <= '0;
            gpio_q    <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state_q   <= S_RSTP;
                        len_q     <= len_d;
                        loop_q    <= LOOP;
                        rcnt_q    <= RCW'(RST_CYC - 1);
                        dut_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                        sw_q      <= '0;
                        key_q     <= '0;
                        gpio_q    <= '0;
                        idx_q     <= '0;
`ifdef STIM_CHECK_EN
                        miscnt_q  <= '0;
                        misidx_q  <= '0;
`endif
                    end
                end
                S_RSTP: begin
                    if (rcnt_q == '0) begin
                        state_q   <= S_PLAY;
                        dut_rst_q <= 1'b0;
                        sw_q      <= ent[O_SW +: SW_W];
                        key_q     <= ent[O_KEY +: KEY_W];
                        gpio_q    <= ent[GPIO_W-1:0];
                        hold_q    <= hold_d;
                        idx_q     <= idx_d;
`ifdef STIM_CHECK_EN
                        exp_q     <= ent[O_EXP +: OBS_W];
`endif
                    end else begin
                        rcnt_q <= rcnt_q - RCW'(1);
                    end
                end
                S_PLAY: begin
                    if (hold_q == '0) begin
`ifdef STIM_CHECK_EN
                        if (OBS != exp_q) begin
                            if (miscnt_q != 16'hFFFF)
                                miscnt_q <= miscnt_q + 16'd1;
                            if (miscnt_q == '0)
                                misidx_q <= idx_q;
                        end
`endif
                        if (last && !loop_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            sw_q   <= ent[O_SW +: SW_W];
                            key_q  <= ent[O_KEY +: KEY_W];
                            gpio_q <= ent[GPIO_W-1:0];
                            hold_q <= hold_d;
                            idx_q  <= idx_d;
`ifdef STIM_CHECK_EN
                            exp_q  <= ent[O_EXP +: OBS_W];
`endif
                        end
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign DUT_RST = dut_rst_q;
    assign SW      = sw_q;
    assign KEY     = key_q;
    assign GPIO    = gpio_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign IDX     = idx_q;
`ifdef STIM_CHECK_EN
    assign MISCNT  = miscnt_q;
    assign MISIDX  = misidx_q;
`endif

endmodule

// File: tb/tb_board_stim_seq.sv
// Bench for board_stim_seq: per-cycle output vectors queued and compared.
// Build with STIM_CHECK_EN defined to also exercise the OBS checker.
module tb_board_stim_seq;

`ifdef STIM_CHECK_EN
    localparam int EW = 65;
`else
    localparam int EW = 60;
`endif
    localparam int RCYC = 2;

    typedef struct packed {
        logic        rst;
        logic [9:0]  sw;
        logic [1:0]  key;
        logic [31:0] gpio;
        logic        busy;
        logic        done;
        logic [3:0]  idx;
    } obs_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          WE;
    logic [3:0]    WADDR;
    logic [EW-1:0] WDATA;
    logic [4:0]    LEN;
    logic          LOOP;
    logic          START;
    logic          ABORT;
    logic [4:0]    OBS;
    logic          DUT_RST;
    logic [9:0]    SW;
    logic [1:0]    KEY;
    logic [31:0]   GPIO;
    logic          BUSY;
    logic          DONE;
    logic [3:0]    IDX;
`ifdef STIM_CHECK_EN
    logic [15:0]   MISCNT;
    logic [3:0]    MISIDX;
`endif

    obs_t        exq[$];
    int          errors = 0;
    int          checks = 0;
    int          mh[16];
    logic [9:0]  msw[16];
    logic [1:0]  mkey[16];
    logic [31:0] mgpio[16];
    logic [4:0]  mexp[16];

    board_stim_seq dut (
        .CLK     (CLK),
        .RST     (RST),
        .WE      (WE),
        .WADDR   (WADDR),
        .WDATA   (WDATA),
        .LEN     (LEN),
        .LOOP    (LOOP),
        .START   (START),
        .ABORT   (ABORT),
        .OBS     (OBS),
        .DUT_RST (DUT_RST),
        .SW      (SW),
        .KEY     (KEY),
        .GPIO    (GPIO),
        .BUSY    (BUSY),
        .DONE    (DONE),
`ifdef STIM_CHECK_EN
        .MISCNT  (MISCNT),
        .MISIDX  (MISIDX),
`endif
        .IDX     (IDX)
    );

    always #5 CLK = ~CLK;

    function automatic obs_t mk(
        input logic        r,
        input logic [9:0]  s,
        input logic [1:0]  k,
        input logic [31:0] g,
        input logic        b,
        input logic        d,
        input logic [3:0]  i
    );
        obs_t v;
        v.rst  = r;
        v.sw   = s;
        v.key  = k;
        v.gpio = g;
        v.busy = b;
        v.done = d;
        v.idx  = i;
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input obs_t want);
        obs_t got;
        got = {DUT_RST, SW, KEY, GPIO, BUSY, DONE, IDX};
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic run_check(input string tag);
        obs_t want;
        while (exq.size() > 0) begin
            tick();
            START = 1'b0;
            ABORT = 1'b0;
            WE    = 1'b0;
            want  = exq.pop_front();
            chk(tag, want);
        end
    endtask

    task automatic wr(
        input int          a,
        input int          h,
        input logic [9:0]  s,
        input logic [1:0]  k,
        input logic [31:0] g,
        input logic [4:0]  e
    );
        mh[a]    = h;
        msw[a]   = s;
        mkey[a]  = k;
        mgpio[a] = g;
        mexp[a]  = e;
        WE    = 1'b1;
        WADDR = 4'(a);
`ifdef STIM_CHECK_EN
        WDATA = {mexp[a], 16'(h), s, k, g};
`else
        WDATA = {16'(h), s, k, g};
`endif
        tick();
        WE = 1'b0;
    endtask

    // Expected output stream from the START edge onward.
    task automatic exp_play(input int len, input bit loop, input int limit);
        int l;
        int i;
        int n;
        int h;
        l = (len > 16) ? 16 : len;
        i = 0;
        n = 0;
        for (int r = 0; r < RCYC; r++)
            exq.push_back(mk(1'b1, '0, '0, '0, 1'b1, 1'b0, '0));
        while (n < limit) begin
            h = (mh[i] == 0) ? 1 : mh[i];
            for (int c = 0; c < h && n < limit; c++) begin
                exq.push_back(mk(1'b0, msw[i], mkey[i], mgpio[i],
                                 1'b1, 1'b0, 4'(i)));
                n++;
            end
            if (i == l - 1) begin
                if (!loop) begin
                    exq.push_back(mk(1'b0, msw[i], mkey[i], mgpio[i],
                                     1'b0, 1'b1, 4'(i)));
                    exq.push_back(mk(1'b0, msw[i], mkey[i], mgpio[i],
                                     1'b0, 1'b0, 4'(i)));
                    break;
                end
                i = 0;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        obs_t zero;
        zero  = mk(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        RST   = 1'b0;
        WE    = 1'b0;
        WADDR = '0;
        WDATA = '0;
        LEN   = 5'd2;
        LOOP  = 1'b0;
        START = 1'b1;
        ABORT = 1'b0;
        OBS   = 5'h04;

        for (int c = 0; c < 3; c++) begin
            tick();
            chk("reset", zero);
        end
        START = 1'b0;
        RST   = 1'b1;
        tick();
        chk("idle", zero);

        wr(0, 3, 10'h002, 2'b00, 32'h0, 5'h04);
        wr(1, 1, 10'h3FF, 2'b11, 32'hDEADBEEF, 5'h04);
        LEN   = 5'd2;
        LOOP  = 1'b0;
        START = 1'b1;
        exp_play(2, 1'b0, 1000);
        run_check("basic");

        wr(0, 0, 10'h055, 2'b01, 32'h12345678, 5'h04);
        wr(1, 2, 10'h2AA, 2'b10, 32'hCAFEF00D, 5'h04);
        LEN   = 5'd2;
        LOOP  = 1'b1;
        START = 1'b1;
        exp_play(2, 1'b1, 10);
        run_check("loop");

        // Write attempt while playing must not reach the table.
        WE    = 1'b1;
        WADDR = 4'd0;
        WDATA = '1;
        tick();
        WE = 1'b0;
        tick();
        ABORT = 1'b1;
        START = 1'b1;
        exq.push_back(zero);
        exq.push_back(zero);
        run_check("abort");

        LEN   = 5'd2;
        LOOP  = 1'b0;
        START = 1'b1;
        exp_play(2, 1'b0, 1000);
        run_check("replay");

        LEN   = 5'd0;
        START = 1'b1;
        for (int c = 0; c < 2; c++)
            exq.push_back(mk(1'b0, msw[1], mkey[1], mgpio[1],
                             1'b0, 1'b0, 4'd1));
        run_check("len0");

        for (int i = 0; i < 16; i++)
            wr(i, i % 3, 10'(i * 37 + 1), 2'(i),
               32'(i) * 32'h01010101, 5'h04);
        LEN   = 5'd17;
        LOOP  = 1'b0;
        START = 1'b1;
        exp_play(17, 1'b0, 1000);
        run_check("clamp");

`ifdef STIM_CHECK_EN
        wr(1, 1, 10'h111, 2'b01, 32'h0, 5'h05);
        LEN   = 5'd2;
        START = 1'b1;
        exp_play(2, 1'b0, 1000);
        run_check("chk_play");
        checks++;
        assert (MISCNT === 16'd1) else begin
            errors++;
            $error("FAIL miscnt: got %0d expected 1", MISCNT);
        end
        checks++;
        assert (MISIDX === 4'd1) else begin
            errors++;
            $error("FAIL misidx: got %0d expected 1", MISIDX);
        end
        START = 1'b1;
        tick();
        START = 1'b0;
        checks++;
        assert (MISCNT === 16'd0) else begin
            errors++;
            $error("FAIL miscnt_clr: got %0d expected 0", MISCNT);
        end
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
